// File: rtl/hamming_tx_if.sv
// Request and serial-line signals of the Hamming(7,4) transmit scheduler.
// master: producers plus line side; slave: the scheduler.
interface hamming_tx_if #(
  parameter int CNT_W = 8
);
  logic             ReqA_Valid;
  logic [3:0]       ReqA_Data;
  logic             ReqA_Ready;
  logic             ReqB_Valid;
  logic [3:0]       ReqB_Data;
  logic             ReqB_Ready;
  logic             TxEn;
  logic             SerOut;
  logic             SerValid;
  logic             FrameStart;
  logic             FrameEnd;
  logic             GrantId;
  logic             Busy;
  logic [CNT_W-1:0] FrameCount;

  modport master (
    output ReqA_Valid, ReqA_Data,
    output ReqB_Valid, ReqB_Data,
    output TxEn,
    input  ReqA_Ready, ReqB_Ready,
    input  SerOut, SerValid,
    input  FrameStart, FrameEnd,
    input  GrantId, Busy, FrameCount
  );

  modport slave (
    input  ReqA_Valid, ReqA_Data,
    input  ReqB_Valid, ReqB_Data,
    input  TxEn,
    output ReqA_Ready, ReqB_Ready,
    output SerOut, SerValid,
    output FrameStart, FrameEnd,
    output GrantId, Busy, FrameCount
  );
endinterface

// File: rtl/hamming_tx_scheduler.sv
// Round-robin arbiter feeding one Hamming(7,4) encoder/serializer.
// Frames go out MSB first with start/end markers and a trailing gap.
module hamming_tx_scheduler #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  hamming_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d,
            d[1] ^ d[2] ^ d[3],
            d[0] ^ d[2] ^ d[3],
            d[0] ^ d[1] ^ d[3]};
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gid_q, gid_d;

  logic rdy_a, rdy_b;
  logic ser, ser_vld, fstart, fend;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      gid_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    rdy_a   = 1'b0;
    rdy_b   = 1'b0;
    ser     = 1'b0;
    ser_vld = 1'b0;
    fstart  = 1'b0;
    fend    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, grant whoever did not win last time.
        rdy_a = bus.ReqA_Valid &
                (~bus.ReqB_Valid | gid_q);
        rdy_b = bus.ReqB_Valid &
                (~bus.ReqA_Valid | ~gid_q);
        if (rdy_a | rdy_b) begin
          sh_d = enc(rdy_a ? bus.ReqA_Data
                           : bus.ReqB_Data);
          gid_d   = rdy_b;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser     = sh_q[6];
        ser_vld = bus.TxEn;
        fstart  = bus.TxEn & (bit_q == 3'd0);
        fend    = bus.TxEn & (bit_q == 3'd6);
        if (bus.TxEn) begin
          sh_d  = {sh_q[5:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd6) begin
            cnt_d   = cnt_q + CNT_W'(1);
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ReqA_Ready = rdy_a;
  assign bus.ReqB_Ready = rdy_b;
  assign bus.SerOut     = ser;
  assign bus.SerValid   = ser_vld;
  assign bus.FrameStart = fstart;
  assign bus.FrameEnd   = fend;
  assign bus.GrantId    = gid_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.FrameCount = cnt_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Scoreboard bench for hamming_tx_scheduler: one instance with a gap,
// one with no gap and a 2-bit frame counter.
module tb_hamming_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hamming_tx_if #(.CNT_W(8)) m ();
  hamming_tx_if #(.CNT_W(2)) w ();

  hamming_tx_scheduler #(
    .GAP_CYCLES(1), .CNT_W(8)
  ) u0 (.Clk(clk), .Rst(rst), .bus(m));

  hamming_tx_scheduler #(
    .GAP_CYCLES(0), .CNT_W(2)
  ) u1 (.Clk(clk), .Rst(rst), .bus(w));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hcode(input logic [3:0] d);
    logic p1, p2, p3;
    p3 = d[1] ^ d[2] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p1 = d[0] ^ d[1] ^ d[3];
    return {d[3], d[2], d[1], d[0], p3, p2, p1};
  endfunction

  // Scoreboard for u0: {grant, codeword} pushed at accept.
  logic [7:0] sbq[$];
  logic [6:0] word;
  int         nb;
  logic       mgid;

  always @(negedge clk) begin
    logic       ea;
    logic [3:0] d;
    logic [7:0] e;
    if (rst) begin
      sbq.delete();
      nb   = 0;
      word = '0;
      mgid = 1'b1;
    end else begin
      if (m.ReqA_Ready | m.ReqB_Ready) begin
        ea = m.ReqA_Valid & (~m.ReqB_Valid | mgid);
        chk("grant", {m.ReqA_Ready, m.ReqB_Ready},
            ea ? 2'b10 : 2'b01);
        d = ea ? m.ReqA_Data : m.ReqB_Data;
        sbq.push_back({~ea, hcode(d)});
        mgid = ~ea;
      end
      if (m.SerValid) begin
        chk("sb_fs", m.FrameStart, nb == 0);
        chk("sb_fe", m.FrameEnd, nb == 6);
        word = {word[5:0], m.SerOut};
        nb++;
        if (nb == 7) begin
          nb = 0;
          if (sbq.size() == 0) chk("sb_empty", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("sb_word", word, e[6:0]);
            chk("sb_gid", m.GrantId, e[7]);
          end
        end
      end
    end
  end

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    m.ReqA_Valid = 0; m.ReqB_Valid = 0;
    w.ReqA_Valid = 0; w.ReqB_Valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_sv", m.SerValid, 0);
    chk("rst_so", m.SerOut, 0);
    chk("rst_busy", m.Busy, 0);
    chk("rst_cnt", m.FrameCount, 0);
    chk("rst_gid", m.GrantId, 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!m.Busy) begin ok = 1; break; end
    end
    chk("idle_wait", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] cw;
    logic [3:0] pat;
    int         last, nv, nf, end_cyc;
    bit         found, done, have_end, pend;
    logic [1:0] ecnt;
    logic [6:0] bw;

    m.ReqA_Valid = 0; m.ReqA_Data = '0;
    m.ReqB_Valid = 0; m.ReqB_Data = '0;
    m.TxEn = 0;
    w.ReqA_Valid = 0; w.ReqA_Data = '0;
    w.ReqB_Valid = 0; w.ReqB_Data = '0;
    w.TxEn = 1;

    // Single A frame, exact timing.
    do_reset();
    m.ReqA_Valid = 1; m.ReqA_Data = 4'b1011;
    m.TxEn = 1;
    @(negedge clk);
    chk("t1_rdy", m.ReqA_Ready, 1);
    chk("t1_rdyb", m.ReqB_Ready, 0);
    @(posedge clk); #1;
    m.ReqA_Valid = 0;
    cw = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("t1_bit", m.SerOut, cw[6-i]);
      chk("t1_fs", m.FrameStart, i == 0);
      chk("t1_fe", m.FrameEnd, i == 6);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_cnt", m.FrameCount, 1);
    chk("t1_gap_sv", m.SerValid, 0);

    // Round robin with both requesters held valid.
    do_reset();
    m.ReqA_Valid = 1; m.ReqA_Data = 4'b0001;
    m.ReqB_Valid = 1; m.ReqB_Data = 4'b1111;
    m.TxEn = 1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (m.ReqA_Ready | m.ReqB_Ready) begin
          found = 1; break;
        end
      end
      chk("rr_seen", found, 1);
      chk("rr_order", m.ReqB_Ready, k % 2);
      if (k > 0) chk("rr_space", cyc - last, 9);
      last = cyc;
    end
    @(posedge clk); #1;
    m.ReqA_Valid = 0; m.ReqB_Valid = 0;
    wait_idle();
    chk("rr_cnt", m.FrameCount, 4);

    // TxEn stalls within a frame.
    m.ReqA_Valid = 1; m.ReqA_Data = 4'b0000;
    m.TxEn = 1;
    @(negedge clk);
    chk("tx_rdy", m.ReqA_Ready, 1);
    @(posedge clk); #1;
    m.ReqA_Valid = 0;
    pat = 4'b1001; nv = 0; done = 0;
    for (int i = 0; i < 40; i++) begin
      m.TxEn = pat[3 - (i % 4)];
      @(negedge clk);
      chk("tx_sv", m.SerValid, m.TxEn);
      if (m.SerValid) begin
        nv++;
        chk("tx_bit", m.SerOut, 0);
        if (m.FrameEnd) begin
          chk("tx_fe_pos", nv, 7);
          done = 1;
        end
      end
      if (done) break;
      @(posedge clk); #1;
    end
    chk("tx_done", done, 1);
    m.TxEn = 1;
    @(posedge clk); #1;

    // Reset on the 4th bit aborts the frame.
    do_reset();
    m.ReqA_Valid = 1; m.ReqA_Data = 4'b1011;
    @(negedge clk);
    chk("ab_rdy", m.ReqA_Ready, 1);
    @(posedge clk); #1;
    m.ReqA_Valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("ab_bit4", m.SerOut, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ab_sv", m.SerValid, 0);
    chk("ab_so", m.SerOut, 0);
    chk("ab_fe", m.FrameEnd, 0);
    chk("ab_busy", m.Busy, 0);
    chk("ab_cnt", m.FrameCount, 0);
    @(posedge clk); #1;
    m.ReqA_Valid = 1;
    @(negedge clk);
    chk("ab_rdy2", m.ReqA_Ready, 1);
    @(posedge clk); #1;
    m.ReqA_Valid = 0;
    wait_idle();
    chk("ab_cnt2", m.FrameCount, 1);

    // No gap, back-to-back B, 2-bit counter wrap.
    do_reset();
    w.ReqB_Valid = 1; w.ReqB_Data = 4'b0110;
    w.TxEn = 1;
    bw = '0; nf = 0; ecnt = '0;
    have_end = 0; pend = 0; end_cyc = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (pend) begin
        chk("wrap_cnt", w.FrameCount, ecnt);
        chk("gap0_idle", w.Busy, 0);
        pend = 0;
        if (nf == 5) break;
      end
      if (w.SerValid) begin
        if (w.FrameStart) begin
          bw = '0;
          if (have_end)
            chk("gap0_space", cyc - end_cyc, 2);
        end
        bw = {bw[5:0], w.SerOut};
        if (w.FrameEnd) begin
          chk("b_word", bw, hcode(4'b0110));
          end_cyc = cyc; have_end = 1;
          nf++; ecnt = ecnt + 2'd1; pend = 1;
        end
      end
    end
    chk("wrap_done", nf, 5);
    w.ReqB_Valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
